// File: rtl/uart_transmit_state_machine.sv
// uart_transmit_state_machine
// ---------------------------------------------------------------------------
// UART transmit engine for the eUSCI_A block. It runs on the baud-rate bit
// clock, so each rising BITCLK edge is one bit period. When the transmit
// buffer holds a character (iTXIFG == 0), the engine takes it and shifts out
// one frame on Tx:
//   start bit, 7 or 8 data bits (LSB- or MSB-first), optional parity,
//   then 1 or 2 stop bits.
// The frame format is latched when the character is loaded, so register
// writes made during a frame only affect the next frame. A character that is
// waiting at the last stop bit is loaded at once, so back-to-back frames have
// no idle bit between them.
//
// Handshake with the register block: TxBEN/setTXIFG pulse for exactly the
// cycle in which TxData is captured. The parent clears the buffer flag on
// that same edge, so iTXIFG reads 1 on the next cycle. setTXCPTIFG pulses
// during the last stop bit only when no further character is waiting.
//
// Ports:
//   BITCLK       in   bit clock, one UART bit period per rising edge
//   reset        in   synchronous, active-low reset
//   wUCPEN       in   parity enable
//   wUCPAR       in   parity select: 0 odd, 1 even
//   wUCMSB       in   1 = MSB-first, 0 = LSB-first
//   wUC7BIT      in   1 = 7-bit data (TxData[6:0]), 0 = 8-bit
//   wUCSPB       in   1 = two stop bits, 0 = one
//   TxData[7:0]  in   transmit buffer contents
//   iTXIFG       in   current UCTXIFG; 0 = buffer holds an unsent character
//   TxBEN        out  buffer-read strobe (combinational)
//   setTXIFG     out  request to set UCTXIFG (combinational)
//   setTXCPTIFG  out  request to set UCTXCPTIFG (combinational)
//   TxBusy       out  frame in progress (registered)
//   Tx           out  serial line, idle high (registered)
// ---------------------------------------------------------------------------
module uart_transmit_state_machine (
    input  logic       BITCLK,
    input  logic       reset,
    input  logic       wUCPEN,
    input  logic       wUCPAR,
    input  logic       wUCMSB,
    input  logic       wUC7BIT,
    input  logic       wUCSPB,
    input  logic [7:0] TxData,
    input  logic       iTXIFG,
    output logic       TxBEN,
    output logic       setTXIFG,
    output logic       setTXCPTIFG,
    output logic       TxBusy,
    output logic       Tx
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    // The state names the bit that Tx is currently driving.
    state_t     state_q, state_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic [7:0] data_q, data_d;
    logic [3:0] cnt_q, cnt_d;      // data bits already placed on Tx
    logic       pen_q, pen_d;
    logic       msb_q, msb_d;
    logic       b7_q, b7_d;
    logic       spb_q, spb_d;
    logic       par_bit_q, par_bit_d;

    logic       last_stop;
    logic       load;
    logic       ones_odd;
    logic [3:0] n_bits;
    logic [2:0] sel_cnt;
    logic [2:0] sel_idx;
    logic       cur_bit;

    assign last_stop = (state_q == STOP2) || ((state_q == STOP1) && !spb_q);
    assign load      = reset && !iTXIFG && ((state_q == IDLE) || last_stop);

    // Parity of the character being loaded, over 7 or 8 bits. Odd parity
    // inverts the raw XOR so the total count of ones becomes odd.
    assign ones_odd  = wUC7BIT ? (^TxData[6:0]) : (^TxData);

    // Data bit to drive next: the first data bit is selected while in
    // START, subsequent ones while in DATA.
    assign n_bits  = b7_q ? 4'd7 : 4'd8;
    assign sel_cnt = (state_q == START) ? 3'd0 : cnt_q[2:0];
    assign sel_idx = msb_q ? ((b7_q ? 3'd6 : 3'd7) - sel_cnt) : sel_cnt;
    assign cur_bit = data_q[sel_idx];

    // State register
    always_ff @(posedge BITCLK) begin
        if (!reset) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            data_q    <= 8'h00;
            cnt_q     <= 4'd0;
            pen_q     <= 1'b0;
            msb_q     <= 1'b0;
            b7_q      <= 1'b0;
            spb_q     <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            pen_q     <= pen_d;
            msb_q     <= msb_d;
            b7_q      <= b7_d;
            spb_q     <= spb_d;
            par_bit_q <= par_bit_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        pen_d     = pen_q;
        msb_d     = msb_q;
        b7_d      = b7_q;
        spb_d     = spb_q;
        par_bit_d = par_bit_q;

        if (load) begin
            data_d    = TxData;
            pen_d     = wUCPEN;
            msb_d     = wUCMSB;
            b7_d      = wUC7BIT;
            spb_d     = wUCSPB;
            par_bit_d = ones_odd ^ ~wUCPAR;
            cnt_d     = 4'd0;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
            state_d   = START;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
                START: begin
                    tx_d    = cur_bit;
                    cnt_d   = 4'd1;
                    state_d = DATA;
                end
                DATA: begin
                    if (cnt_q == n_bits) begin
                        if (pen_q) begin
                            tx_d    = par_bit_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP1;
                        end
                    end else begin
                        tx_d  = cur_bit;
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                PARITY: begin
                    tx_d    = 1'b1;
                    state_d = STOP1;
                end
                STOP1: begin
                    tx_d = 1'b1;
                    if (spb_q) begin
                        state_d = STOP2;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                STOP2: begin
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: begin
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        TxBEN       = load;
        setTXIFG    = load;
        setTXCPTIFG = reset && last_stop && iTXIFG;
        TxBusy      = busy_q;
        Tx          = tx_q;
    end

endmodule

// File: tb/tb_uart_transmit_state_machine.sv
// Directed bench for uart_transmit_state_machine. Expected Tx sequences are
// hand-written bit strings (first transmitted bit on the left) that are
// queued into a scoreboard and popped one per bit period.
module tb_uart_transmit_state_machine;

    logic       BITCLK;
    logic       reset;
    logic       wUCPEN;
    logic       wUCPAR;
    logic       wUCMSB;
    logic       wUC7BIT;
    logic       wUCSPB;
    logic [7:0] TxData;
    logic       iTXIFG;
    logic       TxBEN;
    logic       setTXIFG;
    logic       setTXCPTIFG;
    logic       TxBusy;
    logic       Tx;

    int         checks_cnt;
    int         fail_cnt;
    logic [0:0] exp_q[$];

    uart_transmit_state_machine dut (
        .BITCLK      (BITCLK),
        .reset       (reset),
        .wUCPEN      (wUCPEN),
        .wUCPAR      (wUCPAR),
        .wUCMSB      (wUCMSB),
        .wUC7BIT     (wUC7BIT),
        .wUCSPB      (wUCSPB),
        .TxData      (TxData),
        .iTXIFG      (iTXIFG),
        .TxBEN       (TxBEN),
        .setTXIFG    (setTXIFG),
        .setTXCPTIFG (setTXCPTIFG),
        .TxBusy      (TxBusy),
        .Tx          (Tx)
    );

    // Clock / reset
    initial BITCLK = 1'b0;
    always #5 BITCLK = ~BITCLK;

    // Checker
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one bit period; sample point is #1 after the rising edge.
    task automatic tick();
        @(posedge BITCLK);
        #1;
    endtask

    // Drive one frame from the current point (IDLE or last stop bit of a
    // previous frame). Returns with the DUT in the new frame's last stop bit.
    task automatic run_frame(input string name, input logic [7:0] data,
                             input logic pen, input logic par, input logic msb,
                             input logic b7, input logic spb,
                             input logic [10:0] bits, input int n, input bit flip);
        logic exp;
        wUCPEN  = pen;
        wUCPAR  = par;
        wUCMSB  = msb;
        wUC7BIT = b7;
        wUCSPB  = spb;
        TxData  = data;
        iTXIFG  = 1'b0;
        #1;
        check({name, "_txben_load"}, TxBEN, 1'b1);
        check({name, "_settxifg_load"}, setTXIFG, 1'b1);
        check({name, "_cpt_on_load"}, setTXCPTIFG, 1'b0);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(bits[i]);
        tick();
        iTXIFG = 1'b1;
        if (flip) begin
            wUCPEN  = ~pen;
            wUCPAR  = ~par;
            wUCMSB  = ~msb;
            wUC7BIT = ~b7;
            wUCSPB  = ~spb;
            TxData  = ~data;
        end
        #1;
        exp = exp_q.pop_front();
        check({name, "_tx_start"}, Tx, exp);
        check({name, "_busy_start"}, TxBusy, 1'b1);
        check({name, "_txben_after"}, TxBEN, 1'b0);
        for (int b = 1; exp_q.size() > 0; b++) begin
            tick();
            exp = exp_q.pop_front();
            check($sformatf("%s_tx_bit%0d", name, b), Tx, exp);
            check($sformatf("%s_busy_bit%0d", name, b), TxBusy, 1'b1);
            check($sformatf("%s_txben_bit%0d", name, b), TxBEN, 1'b0);
            if (exp_q.size() > 0)
                check($sformatf("%s_cpt_bit%0d", name, b), setTXCPTIFG, 1'b0);
        end
    endtask

    // Let the frame end with nothing waiting.
    task automatic finish_idle(input string name);
        check({name, "_cpt_last_stop"}, setTXCPTIFG, 1'b1);
        tick();
        check({name, "_tx_idle"}, Tx, 1'b1);
        check({name, "_busy_idle"}, TxBusy, 1'b0);
        check({name, "_cpt_idle"}, setTXCPTIFG, 1'b0);
        check({name, "_txben_idle"}, TxBEN, 1'b0);
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        reset   = 1'b0;
        iTXIFG  = 1'b1;
        wUCPEN  = 1'b0;
        wUCPAR  = 1'b0;
        wUCMSB  = 1'b0;
        wUC7BIT = 1'b0;
        wUCSPB  = 1'b0;
        TxData  = 8'h00;
        tick();
        tick();
        check("rst_tx", Tx, 1'b1);
        check("rst_busy", TxBusy, 1'b0);
        check("rst_txben", TxBEN, 1'b0);
        check("rst_settxifg", setTXIFG, 1'b0);
        check("rst_cpt", setTXCPTIFG, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        check("idle_tx", Tx, 1'b1);
        check("idle_busy", TxBusy, 1'b0);
        check("idle_txben", TxBEN, 1'b0);
        check("idle_cpt", setTXCPTIFG, 1'b0);

        // 8N1 LSB-first, 0xA5
        run_frame("a5_8n1", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b0101001011, 10, 1'b0);
        finish_idle("a5_8n1");
        tick();

        // Back-to-back: 0x55 then 0xFF loaded during the stop bit
        run_frame("b2b_55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b0101010101, 10, 1'b0);
        run_frame("b2b_ff", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b0111111111, 10, 1'b0);
        finish_idle("b2b_ff");

        // 7-bit, odd parity, 2 stop, MSB-first
        run_frame("o35", 8'h35, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 11'b00110101111, 11, 1'b0);
        finish_idle("o35");
        run_frame("o24", 8'h24, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 11'b00100100111, 11, 1'b0);
        finish_idle("o24");
        run_frame("e35", 8'h35, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 11'b00110101011, 11, 1'b0);
        finish_idle("e35");

        // 7-bit MSB-first ignores TxData[7]: 0xB5 sends like 0x35
        run_frame("o_b5", 8'hB5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 11'b00110101111, 11, 1'b0);
        finish_idle("o_b5");

        // Config (and buffer) changes right after the load edge have no effect
        run_frame("flip", 8'h35, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 11'b00110101111, 11, 1'b1);
        finish_idle("flip");
        wUCPEN  = 1'b0;
        wUCPAR  = 1'b0;
        wUCMSB  = 1'b0;
        wUC7BIT = 1'b0;
        wUCSPB  = 1'b0;

        // Reset mid-DATA aborts the frame
        TxData = 8'h00;
        iTXIFG = 1'b0;
        tick();
        iTXIFG = 1'b1;
        tick();
        tick();
        tick();
        check("abort_busy_before", TxBusy, 1'b1);
        reset  = 1'b0;
        iTXIFG = 1'b0;
        #1;
        check("abort_txben_forced", TxBEN, 1'b0);
        check("abort_settxifg_forced", setTXIFG, 1'b0);
        check("abort_cpt_forced", setTXCPTIFG, 1'b0);
        tick();
        check("abort_tx", Tx, 1'b1);
        check("abort_busy", TxBusy, 1'b0);
        check("abort_txben", TxBEN, 1'b0);
        reset  = 1'b1;
        iTXIFG = 1'b1;
        tick();
        check("abort_idle_tx", Tx, 1'b1);
        run_frame("fresh_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b0101001011, 10, 1'b0);
        finish_idle("fresh_a5");

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
